light_phase_timer: RTL and testbench

//  Upstream timing stage for the red/amber/green light sequencer. Holds each phase
//  (RED -> RED_AMBER -> GREEN -> AMBER -> RED) for a parameterised number of enabled

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/phase_down_counter.sv | 38 +++
 rtl/light_phase_timer.sv | 126 ++++++++++++
 tb/tb_light_phase_timer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and phase-order helper for the light timer and sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_e;

    function automatic phase_e next_phase(input phase_e ph);
        next_phase = PH_RED;
        unique case (ph)
            PH_RED:       next_phase = PH_RED_AMBER;
            PH_RED_AMBER: next_phase = PH_GREEN;
            PH_GREEN:     next_phase = PH_AMBER;
            PH_AMBER:     next_phase = PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter with zero flag; holds at zero unless reloaded.
module phase_down_counter #(
    parameter int unsigned       CNT_W   = 8,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/light_phase_timer.sv
// Phase hold timer for the light sequencer; pedestrian RED extension built only when
// PED_REQ_EN is defined.
module light_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned T_RED   = 20,
    parameter int unsigned T_RA    = 4,
    parameter int unsigned T_GREEN = 20,
    parameter int unsigned T_AMBER = 4,
    parameter int unsigned T_PED   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_ped_req,
    output logic             o_step,
    output logic [1:0]       o_phase,
    output logic [CNT_W-1:0] o_remain,
    output logic             o_ped_ack,
    output logic             o_ped_walk
);

    if (T_RED < 1 || T_RA < 1 || T_GREEN < 1 || T_AMBER < 1 ||
        T_RA > 2 ** CNT_W || T_GREEN > 2 ** CNT_W || T_AMBER > 2 ** CNT_W ||
        (T_RED + T_PED) > 2 ** CNT_W) begin : g_cfg_check
        $error("light_phase_timer: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] L_RED     = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] L_RED_PED = CNT_W'(T_RED + T_PED - 1);
    localparam logic [CNT_W-1:0] L_RA      = CNT_W'(T_RA - 1);
    localparam logic [CNT_W-1:0] L_GREEN   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] L_AMBER   = CNT_W'(T_AMBER - 1);

    phase_e           r_phase, w_phase_d;
    logic             r_step, w_step_d;
    logic             r_ped_ack, w_ped_ack_d;
    logic             r_ped_walk, w_ped_walk_d;
    logic             w_zero, w_adv, w_serve;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_remain;

    assign w_adv = i_enable && w_zero;

`ifdef PED_REQ_EN
    logic r_pending, w_pending_d;

    // A request arriving on the service edge is consumed by that service.
    always_comb begin
        w_serve     = w_adv && (r_phase == PH_AMBER) && (r_pending || i_ped_req);
        w_pending_d = w_serve ? 1'b0 : (r_pending || i_ped_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
        end
    end
`else
    logic w_unused_ped_req;
    assign w_unused_ped_req = i_ped_req;
    assign w_serve          = 1'b0;
`endif

    always_comb begin
        w_phase_d    = r_phase;
        w_step_d     = 1'b0;
        w_ped_ack_d  = 1'b0;
        w_ped_walk_d = r_ped_walk;
        if (w_adv) begin
            w_phase_d = next_phase(r_phase);
            w_step_d  = 1'b1;
            if (r_phase == PH_RED) begin
                w_ped_walk_d = 1'b0;
            end
            if (w_serve) begin
                w_ped_ack_d  = 1'b1;
                w_ped_walk_d = 1'b1;
            end
        end
        w_load_val = L_RED;
        unique case (w_phase_d)
            PH_RED:       w_load_val = w_serve ? L_RED_PED : L_RED;
            PH_RED_AMBER: w_load_val = L_RA;
            PH_GREEN:     w_load_val = L_GREEN;
            PH_AMBER:     w_load_val = L_AMBER;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PH_RED;
            r_step     <= 1'b0;
            r_ped_ack  <= 1'b0;
            r_ped_walk <= 1'b0;
        end else begin
            r_phase    <= w_phase_d;
            r_step     <= w_step_d;
            r_ped_ack  <= w_ped_ack_d;
            r_ped_walk <= w_ped_walk_d;
        end
    end

    phase_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (L_RED)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_adv),
        .i_load_val (w_load_val),
        .i_dec      (i_enable),
        .o_count    (w_remain),
        .o_zero     (w_zero)
    );

    assign o_step     = r_step;
    assign o_phase    = r_phase;
    assign o_remain   = w_remain;
    assign o_ped_ack  = r_ped_ack;
    assign o_ped_walk = r_ped_walk;

endmodule

// File: tb/tb_light_phase_timer.sv
// Randomized bench for light_phase_timer against an elapsed-count phase model.
module tb_light_phase_timer;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned T_RED   = 3;
    localparam int unsigned T_RA    = 1;
    localparam int unsigned T_GREEN = 2;
    localparam int unsigned T_AMBER = 1;
    localparam int unsigned T_PED   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             ped_req = 1'b0;
    logic             step;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remain;
    logic             ped_ack;
    logic             ped_walk;

    int n_checks = 0;
    int n_errors = 0;

    int dur [4];
    int m_ph, m_elapsed, m_dur;
    bit m_pend, m_walk, m_step, m_ack;

    light_phase_timer #(
        .CNT_W   (CNT_W),
        .T_RED   (T_RED),
        .T_RA    (T_RA),
        .T_GREEN (T_GREEN),
        .T_AMBER (T_AMBER),
        .T_PED   (T_PED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (enable),
        .i_ped_req  (ped_req),
        .o_step     (step),
        .o_phase    (phase),
        .o_remain   (remain),
        .o_ped_ack  (ped_ack),
        .o_ped_walk (ped_walk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph      = 0;
        m_elapsed = 0;
        m_dur     = T_RED;
        m_pend    = 1'b0;
        m_walk    = 1'b0;
        m_step    = 1'b0;
        m_ack     = 1'b0;
    endtask

    // Each phase lasts m_dur enabled cycles; it ends on the edge where the
    // elapsed count reaches m_dur-1.
    task automatic model_edge(input bit en, input bit req);
        m_step = 1'b0;
        m_ack  = 1'b0;
        if (en && m_elapsed == m_dur - 1) begin
            bit serve = 1'b0;
`ifdef PED_REQ_EN
            serve = (m_ph == 3) && (m_pend || req);
            if (m_ph == 0) m_walk = 1'b0;
            if (serve) begin
                m_pend = 1'b0;
                m_ack  = 1'b1;
                m_walk = 1'b1;
            end else begin
                m_pend = m_pend | req;
            end
`else
            m_pend = m_pend | req;
`endif
            m_ph      = (m_ph + 1) % 4;
            m_dur     = dur[m_ph] + (serve ? T_PED : 0);
            m_elapsed = 0;
            m_step    = 1'b1;
        end else begin
            if (en) m_elapsed++;
            m_pend = m_pend | req;
        end
    endtask

    task automatic check_outputs();
        check("phase", 32'(phase), 32'(m_ph));
        check("remain", 32'(remain), 32'(m_dur - 1 - m_elapsed));
        check("step", 32'(step), 32'(m_step));
        check("ped_ack", 32'(ped_ack), 32'(m_ack));
        check("ped_walk", 32'(ped_walk), 32'(m_walk));
    endtask

    task automatic run_cycle(input bit en, input bit req);
        enable  = en;
        ped_req = req;
        @(posedge clk);
        model_edge(en, req);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        dur[0] = T_RED;
        dur[1] = T_RA;
        dur[2] = T_GREEN;
        dur[3] = T_AMBER;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Walk the sequence, then freeze mid-GREEN for five cycles.
        repeat (4) run_cycle(1'b1, 1'b0);
        repeat (5) run_cycle(1'b0, 1'b0);
        repeat (10) run_cycle(1'b1, 1'b0);

        // Request pulse in GREEN.
        for (int i = 0; i < 20 && m_ph != 2; i++) run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b1);
        repeat (12) run_cycle(1'b1, 1'b0);

        // Request on the AMBER->RED edge, then another inside the serviced RED.
        for (int i = 0; i < 20 && !(m_ph == 3 && m_elapsed == m_dur - 1); i++)
            run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b1);
        repeat (15) run_cycle(1'b1, 1'b0);

        repeat (400) run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 20 && m_ph != 2; i++) run_cycle(1'b1, 1'b0);
        enable  = 1'b1;
        ped_req = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        repeat (300) run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
